// File: rtl/mem_test_pkg.sv
// Shared constants for the memory-test sequencer and its datapath: state codes,
// pass count and the last address of the 32K sweep.
package mem_test_pkg;

  localparam int unsigned NUM_PASSES = 4;
  localparam logic [14:0] ADDR_LAST  = 15'h7FFF;

  // ST_READ is also the datapath's compare qualifier
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_WSETUP = 3'b001,
    ST_WLOAD  = 3'b010,
    ST_WRITE  = 3'b011,
    ST_READ   = 3'b100,
    ST_RSETUP = 3'b101,
    ST_RLOAD  = 3'b110,
    ST_NEXT   = 3'b111
  } state_e;

  function automatic logic is_access(input state_e s);
    return (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Wait counter for one memory access: loaded with the extra wait count on entry,
// counts down to zero; flags the last and next-to-last cycles of the access.
module mem_access_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] wait_i,
  output logic       last_o,
  output logic       penult_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = wait_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o   = (cnt_q == 4'd0);
  assign penult_o = (cnt_q == 4'd1);

endmodule

// File: rtl/mem_test_seq.sv
// Sequencer for the 32K x 16 memory test: runs write/read-compare passes, drives
// the datapath load strobes and RAM strobes, reports busy/complete/fail.
module mem_test_seq
  import mem_test_pkg::*;
#(
  parameter int unsigned NUM_PASSES  = mem_test_pkg::NUM_PASSES,
  parameter int unsigned WAIT_CYC    = 0,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  input  logic       finish,
  input  logic       error,
  output logic       loadA,
  output logic       loadD,
  output logic [2:0] pass,
  output logic [2:0] state,
  output logic       we_n,
  output logic       oe_n,
  output logic       busy,
  output logic       complete,
  output logic       fail
);

  localparam logic [3:0] WaitCnt   = 4'(WAIT_CYC);
  localparam logic       EntryLast = (WAIT_CYC == 0);

  state_e     state_q;
  logic [2:0] pass_q;
  logic       loadA_q;
  logic       loadD_q;
  logic       we_n_q;
  logic       oe_n_q;
  logic       busy_q;
  logic       complete_q;
  logic       fail_q;

  logic       tmr_load;
  logic       tmr_last;
  logic       tmr_penult;

  assign tmr_load = (state_q == ST_WLOAD) || (state_q == ST_RLOAD);

  mem_access_timer u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (tmr_load),
    .wait_i   (WaitCnt),
    .last_o   (tmr_last),
    .penult_o (tmr_penult)
  );

  // Strobes are registered, so loadA for the final access cycle is decided on
  // the edge that enters that cycle; done is stable for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      loadA_q    <= 1'b0;
      loadD_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      loadA_q <= 1'b0;
      loadD_q <= 1'b0;
      if (STOP_ON_ERR && (state_q != ST_IDLE) && error) begin
        state_q    <= ST_IDLE;
        we_n_q     <= 1'b1;
        oe_n_q     <= 1'b1;
        busy_q     <= 1'b0;
        complete_q <= 1'b0;
        fail_q     <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && !finish) begin
              state_q    <= ST_WSETUP;
              loadA_q    <= 1'b1;
              busy_q     <= 1'b1;
              complete_q <= 1'b0;
              fail_q     <= 1'b0;
            end
          end
          ST_WSETUP: begin
            state_q <= ST_WLOAD;
            loadD_q <= 1'b1;
          end
          ST_WLOAD: begin
            state_q <= ST_WRITE;
            we_n_q  <= 1'b0;
            loadA_q <= EntryLast && !done;
          end
          ST_WRITE: begin
            if (tmr_last) begin
              we_n_q <= 1'b1;
              if (done) begin
                state_q <= ST_RSETUP;
                loadA_q <= 1'b1;
              end else begin
                state_q <= ST_WLOAD;
                loadD_q <= 1'b1;
              end
            end else begin
              loadA_q <= tmr_penult && !done;
            end
          end
          ST_RSETUP: begin
            state_q <= ST_RLOAD;
            loadD_q <= 1'b1;
          end
          ST_RLOAD: begin
            state_q <= ST_READ;
            oe_n_q  <= 1'b0;
            loadA_q <= EntryLast && !done;
          end
          ST_READ: begin
            if (tmr_last) begin
              oe_n_q <= 1'b1;
              if (done) begin
                state_q <= ST_NEXT;
                pass_q  <= pass_q + 3'd1;
              end else begin
                state_q <= ST_RLOAD;
                loadD_q <= 1'b1;
              end
            end else begin
              loadA_q <= tmr_penult && !done;
            end
          end
          ST_NEXT: begin
            if (finish) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              complete_q <= 1'b1;
              fail_q     <= error;
            end else begin
              state_q <= ST_WSETUP;
              loadA_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign loadA    = loadA_q;
  assign loadD    = loadD_q;
  assign pass     = pass_q;
  assign state    = state_q;
  assign we_n     = we_n_q;
  assign oe_n     = oe_n_q;
  assign busy     = busy_q;
  assign complete = complete_q;
  assign fail     = fail_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst) !(!we_n_q && !oe_n_q));
  a_load_excl:   assert property (@(posedge clk) disable iff (!rst) !(loadA_q && loadD_q));
  a_busy:        assert property (@(posedge clk) disable iff (!rst) busy_q == (state_q != ST_IDLE));
  a_access:      assert property (@(posedge clk) disable iff (!rst)
                                  (!we_n_q || !oe_n_q) |-> is_access(state_q));
  a_finish:      assert property (@(posedge clk) disable iff (!rst)
                                  finish |-> (pass_q == 3'(NUM_PASSES)));

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq: emulates the address/data/error datapath and RAM, and
// checks every cycle against an expected trace built from the pass/sweep rules.
module tb_mem_test_seq;
  import mem_test_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       la;
    logic       ld;
    logic       we;
    logic       oe;
    logic [2:0] ps;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_v [2];
  logic [14:0] last_addr = 15'd2;
  logic        corrupt = 1'b0;

  logic        la_o [2];
  logic        ld_o [2];
  logic        we_o [2];
  logic        oe_o [2];
  logic        busy_o [2];
  logic        cmp_o [2];
  logic        fail_o [2];
  logic [2:0]  ps_o [2];
  logic [2:0]  st_o [2];

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [2:0] p, input logic [14:0] a);
    case (p)
      3'd0:    return ~{1'b0, a};
      3'd1:    return {1'b0, a};
      3'd2:    return 16'h5555;
      default: return 16'hAAAA;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    logic        loadA, loadD, we_n, oe_n, busy, complete, fail, done, finish, error;
    logic [2:0]  pass, state;
    logic [14:0] addr;
    logic [15:0] dreg;
    logic [15:0] mem [0:32767];

    mem_test_seq #(
      .NUM_PASSES (4),
      .WAIT_CYC   ((g == 0) ? 0 : 3),
      .STOP_ON_ERR(g == 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_v[g]),
      .done    (done),
      .finish  (finish),
      .error   (error),
      .loadA   (loadA),
      .loadD   (loadD),
      .pass    (pass),
      .state   (state),
      .we_n    (we_n),
      .oe_n    (oe_n),
      .busy    (busy),
      .complete(complete),
      .fail    (fail)
    );

    assign done   = (addr == last_addr);
    assign finish = (pass == 3'(NUM_PASSES));

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        addr  <= ADDR_LAST;
        dreg  <= '0;
        error <= 1'b0;
      end else begin
        if (loadA) addr <= (addr == last_addr) ? 15'd0 : addr + 15'd1;
        if (loadD) dreg <= pat(pass, addr);
        if (!we_n) mem[addr] <= (corrupt && pass == 3'd2 && addr == 15'h0100) ? ~dreg : dreg;
        if (!oe_n && state == ST_READ && mem[addr] != dreg) error <= 1'b1;
      end
    end

    assign la_o[g]   = loadA;
    assign ld_o[g]   = loadD;
    assign we_o[g]   = we_n;
    assign oe_o[g]   = oe_n;
    assign busy_o[g] = busy;
    assign cmp_o[g]  = complete;
    assign fail_o[g] = fail;
    assign ps_o[g]   = pass;
    assign st_o[g]   = state;

    always @(negedge clk) begin
      if (rst === 1'b1) begin
        n_checks++;
        if ((!we_n && !oe_n) || (loadA && loadD) || (busy != (state != 3'd0))) begin
          n_fail++;
          $display("FAIL invariant[%0d]: we_n=%b oe_n=%b loadA=%b loadD=%b busy=%b state=%b required exclusive strobes and busy==(state!=0)",
                   g, we_n, oe_n, loadA, loadD, busy, state);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [2:0] s, input logic la, input logic ld,
                              input logic we, input logic oe, input int p);
    exp_t e;
    e.st = s; e.la = la; e.ld = ld; e.we = we; e.oe = oe; e.ps = 3'(p);
    return e;
  endfunction

  // Expected per-cycle trace of one run: passes x (setup, per-address load + access).
  task automatic build(input int n, input int w, input bit stop, input int err_pass, input int err_addr);
    int cut;
    cut = 0;
    q.delete();
    for (int p = 0; p < int'(NUM_PASSES); p++) begin
      q.push_back(mk(ST_WSETUP, 1, 0, 1, 1, p));
      for (int a = 0; a < n; a++) begin
        q.push_back(mk(ST_WLOAD, 0, 1, 1, 1, p));
        for (int k = 0; k <= w; k++) q.push_back(mk(ST_WRITE, (k == w) && (a != n - 1), 0, 0, 1, p));
      end
      q.push_back(mk(ST_RSETUP, 1, 0, 1, 1, p));
      for (int a = 0; a < n; a++) begin
        q.push_back(mk(ST_RLOAD, 0, 1, 1, 1, p));
        for (int k = 0; k <= w; k++) begin
          q.push_back(mk(ST_READ, (k == w) && (a != n - 1), 0, 1, 0, p));
          if (stop && cut == 0 && p == err_pass && a == err_addr && k == 0) cut = q.size() + 1;
        end
      end
      q.push_back(mk(ST_NEXT, 0, 0, 1, 1, p + 1));
    end
    if (cut > 0) while (q.size() > cut) void'(q.pop_back());
  endtask

  function automatic logic [12:0] obs(input int g);
    return {st_o[g], la_o[g], ld_o[g], we_o[g], oe_o[g], busy_o[g], ps_o[g], cmp_o[g], fail_o[g]};
  endfunction

  task automatic cmp(input string nm, input logic [12:0] act, input logic [12:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {st,lA,lD,we_n,oe_n,busy,pass,cmp,fail}=%b required %b", nm, act, req);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic run(input int g, input int n, input int w, input bit stop, input bit corr,
                     input bit exp_fail, input bit hold_start, input string tag);
    logic [2:0] end_pass;
    bit         cut;
    last_addr = 15'(n - 1);
    corrupt   = corr;
    build(n, w, stop, 2, 16'h0100);
    cut      = (q.size() != (4 * (4 * n * (1 + w) / (1 + w) + 0) + 0)) && stop && corr;
    end_pass = cut ? q[q.size() - 1].ps : 3'(NUM_PASSES);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    cmp({tag, " reset"}, obs(g), 13'b000_0_0_1_1_0_000_0_0);
    rst = 1'b1;
    @(negedge clk) start_v[g] = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (!hold_start) start_v[g] = 1'b0;
      cmp($sformatf("%s cyc%0d", tag, i), obs(g),
          {q[i].st, q[i].la, q[i].ld, q[i].we, q[i].oe, 1'b1, q[i].ps, 1'b0, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp($sformatf("%s idle%0d", tag, i), obs(g),
          {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, end_pass, !cut, exp_fail});
    end
    start_v[g] = 1'b0;
  endtask

  initial begin
    logic [2:0] ord [11];
    int         nwe, noe;
    bit         found;
    ord = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100};
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;

    build(3, 0, 0, 2, 256);
    cmp_int("model len n3w0", q.size(), 60);
    nwe = 0; noe = 0;
    foreach (q[i]) begin
      if (!q[i].we) nwe++;
      if (!q[i].oe) noe++;
    end
    cmp_int("model we_n low n3w0", nwe, 12);
    cmp_int("model oe_n low n3w0", noe, 12);
    for (int i = 1; i < 11; i++) cmp_int($sformatf("model order%0d", i), int'(q[i - 1].st), int'(ord[i]));
    build(3, 3, 0, 2, 256);
    cmp_int("model len n3w3", q.size(), 132);
    build(260, 0, 0, 2, 256);
    cmp_int("model len n260w0", q.size(), 4172);

    run(0, 3, 0, 0, 0, 0, 1, "short");

    last_addr = 15'd2;
    corrupt   = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) start_v[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (we_o[0] === 1'b0) found = 1'b1;
    end
    cmp_int("midwrite reached we_n low", int'(found), 1);
    #1 rst = 1'b0;
    #1 cmp("midwrite async reset", obs(0), 13'b000_0_0_1_1_0_000_0_0);
    run(0, 3, 0, 0, 0, 0, 1, "restart");

    run(0, 260, 0, 0, 1, 1, 0, "corrupt");
    run(1, 3, 3, 1, 0, 0, 0, "wait3");
    run(1, 260, 3, 1, 1, 1, 0, "stoperr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_test_seq.md
Name: mem_test_seq

Overview:
- Sequencing controller for the 32K x 16 memory-test supplemental datapath: address register, data register, pattern mux and error latch.
- Runs NUM_PASSES write/read-compare passes over the whole memory.
- Drives loadA, loadD, pass and state into the datapath, and the memory strobes to the RAM.
- Consumes done, finish and error back from the datapath; reports busy, completion and pass/fail to the top level (LEDs).

Parameters:
- NUM_PASSES, 4, number of pattern passes; finish compare value, must match the datapath.
- WAIT_CYC, 0, extra wait cycles held on each memory access (0..15) for slow RAM.
- STOP_ON_ERR, 0, 1 = abort to IDLE on the first latched error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  level; sampled in IDLE only
- done  in  1  datapath: address register == 7FFF
- finish  in  1  datapath: pass == NUM_PASSES
- error  in  1  datapath: latched compare error
- loadA  out  1  increment address register (wraps 7FFF -> 0000)
- loadD  out  1  load data register from pattern mux
- pass  out  3  current pass index 0..NUM_PASSES
- state  out  3  state code (encoding below); 3'b100 is the compare state
- we_n  out  1  memory write strobe, active-low
- oe_n  out  1  memory output enable, active-low
- busy  out  1  test in progress
- complete  out  1  sticky: all passes ran
- fail  out  1  sticky: complete or abort with error set

Behaviour:
- Reset (rst=0, async): state=IDLE, pass=0, wait counter=0, complete=0, fail=0. All strobes deasserted: loadA=0, loadD=0, we_n=1, oe_n=1, busy=0.
- Reset mid-test aborts immediately with no memory strobe glitch; outputs are registered.
- State encoding:
  - IDLE=000, WSETUP=001, WLOAD=010, WRITE=011
  - READ=100, RSETUP=101, RLOAD=110, NEXT=111
- IDLE: busy=0. If start=1 and finish=0, go to WSETUP and clear complete/fail. If start=1 and finish=1, stay in IDLE (re-arm requires reset).
- WSETUP: loadA=1 for one cycle (7FFF -> 0000), then WLOAD.
- WLOAD: loadD=1 for one cycle (pattern for current address), then WRITE.
- WRITE:
  - we_n=0 for 1+WAIT_CYC cycles, timed by a 4-bit counter.
  - On the last cycle, if done=1, go to RSETUP.
  - Otherwise assert loadA the same cycle and go to WLOAD.
- RSETUP/RLOAD: same as WSETUP/WLOAD, then READ.
- READ:
  - oe_n=0 for 1+WAIT_CYC cycles; the datapath compares during state=100.
  - On the last cycle, if done=1, go to NEXT; otherwise assert loadA and go to RLOAD.
- NEXT: pass <= pass+1 (3-bit). Next cycle, if finish=1, go to IDLE with complete=1 and fail=error. Otherwise go to WSETUP.
- STOP_ON_ERR=1: error=1 seen in any non-IDLE state forces IDLE next cycle with fail=1, complete=0. pass is held at its value for debug.
- Invariants: we_n and oe_n never both 0; loadA and loadD never both 1; busy=1 in every state except IDLE.
- Cycle count per pass with WAIT_CYC=0: 1 + 2*32768 + 1 + 2*32768 + 1 = 131075.
- done is only acted on in the last cycle of WRITE/READ. The address-7FFF access is performed and the sweep then ends; the datapath masks the compare there.

Decomposition:
- Shared package mem_test_pkg holds:
  - the state codes as localparams, in particular ST_READ=3'b100, which the datapath error qualifier also uses;
  - the pass constants, NUM_PASSES=4;
  - the ADDR_LAST=15'h7FFF constant.
- One sub-module is natural: mem_access_timer, a 4-bit wait counter with load/last outputs, shared by WRITE and READ.

Test Plan:
- Reset then start=1, bench drives done high on the 3rd address of each sweep:
  - required order 000, 001, 010, 011, 010, 011, 010, 011, 101, 110, 100, ...;
  - exactly 3 we_n=0 and 3 oe_n=0 cycles per pass;
  - pass counts 0 -> 4;
  - complete=1, fail=0.
- Full 32K model with datapath attached, WAIT_CYC=0:
  - pass 0 writes ~addr, pass 1 addr, pass 2 5555, pass 3 AAAA;
  - complete after 4*131075 cycles +/-2;
  - fail=0.
- Memory model corrupts address 0x0100 in pass 2: error latches; fail=1 at complete; with STOP_ON_ERR=1, IDLE within 1 cycle of error with pass=2.
- WAIT_CYC=3: each we_n/oe_n low pulse is exactly 4 cycles; loadA only on the 4th.
- rst=0 asserted mid-WRITE with we_n=0: we_n=1 and state=000 without waiting for a clock edge; pass=0; restart behaves as in test 1.
- start held high through completion: no restart while finish=1; we_n and oe_n never low together (assertion).
